// File: rtl/tt_uart_pkg.sv
// tt_uart_pkg: receiver state encoding and framing defaults shared by the UART blocks
package tt_uart_pkg;
    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 16;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;
endpackage

// File: rtl/tt_sync2.sv
// tt_sync2: two-flop synchronizer for an asynchronous pin, reset to RST_VAL
module tt_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q, meta} <= {RST_VAL, RST_VAL};
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/tt_uart_rx.sv
// tt_uart_rx: 8N1 UART receiver with ready/valid byte output.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data (8E1).
module tt_uart_rx
    import tt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = PARITY;
`else
    localparam rx_state_e AFTER_DATA = STOP;
`endif

    rx_state_e            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 rx_s, par_bad, par_bad_n, deliver, ferr;
    logic                 half_tick, bit_tick;

    tt_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx_i), .q(rx_s));

    assign half_tick = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign bit_tick  = cnt == CW'(CLKS_PER_BIT - 1);
    assign busy_o    = state != IDLE;

`ifdef UART_RX_PARITY_EN
    logic perr;
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_n     = bit_idx;
        shift_n   = shift;
        par_bad_n = par_bad;
        deliver   = 1'b0;
        ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr      = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_n     = '0;
                par_bad_n = 1'b0;
                state_n   = rx_s ? IDLE : START;
            end
            // Mid-start-bit recheck rejects short glitches on the idle line
            START: if (half_tick) begin
                cnt_n   = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (bit_tick) begin
                cnt_n   = '0;
                shift_n = {rx_s, shift[DATA_BITS-1:1]};
                bit_n   = bit_idx + 1'b1;
                state_n = (bit_idx == BW'(DATA_BITS - 1)) ? AFTER_DATA : DATA;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (bit_tick) begin
                cnt_n   = '0;
                state_n = STOP;
                if (^{rx_s, shift}) begin
                    par_bad_n = 1'b1;
                    perr      = 1'b1;
                end
            end
`endif
            STOP: if (bit_tick) begin
                cnt_n   = '0;
                deliver = rx_s & ~par_bad;
                ferr    = ~rx_s;
                state_n = rx_s ? IDLE : BREAK;
            end
            BREAK: begin
                cnt_n   = '0;
                state_n = rx_s ? IDLE : BREAK;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            par_bad     <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_n;
            shift       <= shift_n;
            par_bad     <= par_bad_n;
            frame_err_o <= ferr;
            overrun_o   <= deliver & valid_o & ~ready_i;
            // A byte consumed on the delivery clock frees the slot for the new one
            if (deliver && !(valid_o && !ready_i)) begin
                data_o  <= shift;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err_o <= 1'b0;
        else     parity_err_o <= perr;
    end
`else
    assign parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_tt_uart_rx.sv
// tb_tt_uart_rx: frame-level model of tt_uart_rx with directed frames and per-cycle output checks
module tb_tt_uart_rx;
    localparam int N = 4;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 11 * N + 1;
`else
    localparam int LAT = 10 * N + 1;
`endif

    logic       clk = 1'b0;
    logic       rst, rx_i, ready_i;
    logic [7:0] data_o;
    logic       valid_o, busy_o, frame_err_o, overrun_o, parity_err_o;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int perr_cnt = 0;

    logic [7:0] dlv   [int];
    bit         fe_at [int];
    bit         pe_at [int];
    logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
    logic [7:0] m_data = 8'h00;

    tt_uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk(clk), .rst(rst), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .busy_o(busy_o), .frame_err_o(frame_err_o),
        .overrun_o(overrun_o), .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Model: a good frame falling after edge c0 is delivered at edge c0+LAT
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
            dlv.delete(); fe_at.delete(); pe_at.delete();
        end else begin
            m_ferr = fe_at.exists(cyc);
            m_perr = pe_at.exists(cyc);
            m_ovr  = 1'b0;
            if (dlv.exists(cyc)) begin
                if (m_valid && !ready_i) m_ovr = 1'b1;
                else begin m_data = dlv[cyc]; m_valid = 1'b1; end
            end else if (m_valid && ready_i) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("valid", 8'(valid_o), 8'(m_valid));
            check("data", data_o, m_data);
            check("frame_err", 8'(frame_err_o), 8'(m_ferr));
            check("overrun", 8'(overrun_o), 8'(m_ovr));
            check("parity_err", 8'(parity_err_o), 8'(m_perr));
            if (parity_err_o) perr_cnt++;
        end
    end

    task automatic hold(input logic v);
        rx_i = v;
        repeat (N) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic flip);
        int c0;
        @(posedge clk);
        #1;
        c0 = cyc;
        if (flip) pe_at[c0 + 10 * N + 1] = 1'b1;
        if (!stop) fe_at[c0 + LAT] = 1'b1;
        else if (!flip) dlv[c0 + LAT] = b;
        hold(1'b0);
        for (int i = 0; i < 8; i++) hold(b[i]);
`ifdef UART_RX_PARITY_EN
        hold(^b ^ flip);
`endif
        hold(stop);
    endtask

    initial begin
        logic [7:0] pats [3];
        pats = '{8'h00, 8'hFF, 8'h81};
        rst = 1'b1; rx_i = 1'b1; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", data_o, 8'h00);
        check("rst_valid", 8'(valid_o), 8'h0);
        check("rst_busy", 8'(busy_o), 8'h0);
        check("rst_ferr", 8'(frame_err_o), 8'h0);
        check("rst_ovr", 8'(overrun_o), 8'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        send(8'hA5, 1'b1, 1'b0);
        @(negedge clk); check("a5_pre", 8'(valid_o), 8'h0);
        @(negedge clk); check("a5_valid", 8'(valid_o), 8'h1); check("a5_data", data_o, 8'hA5);
        @(negedge clk); check("a5_clear", 8'(valid_o), 8'h0);

        @(posedge clk); #1 rx_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_start", 8'(busy_o), 8'h1);
        repeat (2) @(negedge clk);
        check("glitch_idle", 8'(busy_o), 8'h0);

        send(8'h3C, 1'b0, 1'b0);
        @(negedge clk); check("fe_pre", 8'(frame_err_o), 8'h0);
        @(negedge clk); check("fe_pulse", 8'(frame_err_o), 8'h1); check("fe_valid", 8'(valid_o), 8'h0);
        repeat (18) @(negedge clk);
        check("break_busy", 8'(busy_o), 8'h1);
        @(posedge clk); #1 rx_i = 1'b1;
        repeat (5) @(negedge clk);
        check("break_idle", 8'(busy_o), 8'h0);

        ready_i = 1'b0;
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        @(negedge clk); check("ovr_pre", 8'(overrun_o), 8'h0);
        @(negedge clk); check("ovr_pulse", 8'(overrun_o), 8'h1);
        check("ovr_keep", data_o, 8'h11); check("ovr_valid", 8'(valid_o), 8'h1);
        @(posedge clk); #1 ready_i = 1'b1;
        @(posedge clk); #1 ready_i = 1'b0;
        @(negedge clk); check("ovr_clear", 8'(valid_o), 8'h0);

        send(8'h33, 1'b1, 1'b0);
        send(8'h44, 1'b1, 1'b0);
        ready_i = 1'b1;
        @(posedge clk); #1 ready_i = 1'b0;
        @(negedge clk);
        check("swap_data", data_o, 8'h44); check("swap_valid", 8'(valid_o), 8'h1);
        check("swap_ovr", 8'(overrun_o), 8'h0);
        ready_i = 1'b1;

        foreach (pats[k]) begin
            send(pats[k], 1'b1, 1'b0);
            repeat (2) @(negedge clk);
            check("pat_data", data_o, pats[k]);
        end

        @(posedge clk); #1 rx_i = 1'b0;
        repeat (N) @(posedge clk);
        #1 rx_i = 1'b1;
        repeat (3 * N) @(posedge clk);
        @(negedge clk); check("mid_busy", 8'(busy_o), 8'h1);
        rst = 1'b1;
        #1;
        check("abort_busy", 8'(busy_o), 8'h0);
        check("abort_data", data_o, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(8'h5A, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("5a_valid", 8'(valid_o), 8'h1); check("5a_data", data_o, 8'h5A);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("par_bad_valid", 8'(valid_o), 8'h0);
        check("par_pulses", 8'(perr_cnt), 8'h1);
        send(8'h07, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("par_ok_valid", 8'(valid_o), 8'h1); check("par_ok_data", data_o, 8'h07);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
